sdram_line_xfer: RTL and testbench

SDRAM_LINE_XFER -- requirements
Module: sdram_line_xfer

---
 rtl/sdram_line_xfer.sv | 181 ++++++++++++++++++
 tb/tb_sdram_line_xfer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_xfer.sv
// Cache-line transfer engine between a cache and a burst SDRAM controller.
// Two line-sized FIFOs decouple the cache from read and write bursts.
module sdram_line_xfer #(
    parameter int unsigned LINEWORDS = 16,
    parameter int unsigned ADDRWIDTH = 19
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 readreq,
    input  logic                 writereq,
    input  logic [ADDRWIDTH-1:0] rd_lineaddr,
    input  logic [ADDRWIDTH-1:0] wr_lineaddr,
    input  logic [15:0]          data_to_ram,
    input  logic                 write,
    output logic                 writeready,
    output logic [15:0]          data_from_ram,
    input  logic                 read,
    output logic                 readready,
    output logic                 busy,
    output logic                 cmd_valid,
    output logic                 cmd_write,
    output logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic                 cmd_ack,
    input  logic [15:0]          sd_rdata,
    input  logic                 sd_rvalid,
    output logic [15:0]          sd_wdata,
    input  logic                 sd_wstrobe
);
    localparam int unsigned CW = $clog2(LINEWORDS) + 1;
    localparam int unsigned PW = (LINEWORDS > 1) ? $clog2(LINEWORDS) : 1;
    localparam logic [CW-1:0] FULL  = CW'(LINEWORDS);
    localparam logic [CW-1:0] LASTW = CW'(LINEWORDS - 1);
    localparam logic [PW-1:0] LASTP = PW'(LINEWORDS - 1);

    typedef enum logic [2:0] {
        StIdle, StRdCmd, StRdData, StWrFill, StWrCmd, StWrData
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        word_q, word_d;
    logic                 pend_q, pend_d;
    logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDRWIDTH-1:0] wr_addr_q, wr_addr_d;

    logic [15:0]   rf_mem [LINEWORDS];
    logic [PW-1:0] rf_wp_q, rf_rp_q;
    logic [CW-1:0] rf_cnt_q;
    logic          rf_push, rf_pop;

    logic [15:0]   wf_mem [LINEWORDS];
    logic [PW-1:0] wf_wp_q, wf_rp_q;
    logic [CW-1:0] wf_cnt_q;
    logic          wf_push, wf_pop;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LASTP) ? '0 : p + 1'b1;
    endfunction

    assign rf_push = (state_q == StRdData) && sd_rvalid && (rf_cnt_q != FULL);
    assign rf_pop  = read && (rf_cnt_q != '0);
    assign wf_push = write && (wf_cnt_q != FULL);
    assign wf_pop  = (state_q == StWrData) && sd_wstrobe && (wf_cnt_q != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_wp_q  <= '0;
            rf_rp_q  <= '0;
            rf_cnt_q <= '0;
            wf_wp_q  <= '0;
            wf_rp_q  <= '0;
            wf_cnt_q <= '0;
        end else begin
            if (rf_push) rf_wp_q <= inc_ptr(rf_wp_q);
            if (rf_pop)  rf_rp_q <= inc_ptr(rf_rp_q);
            if (rf_push && !rf_pop) rf_cnt_q <= rf_cnt_q + 1'b1;
            else if (rf_pop && !rf_push) rf_cnt_q <= rf_cnt_q - 1'b1;
            if (wf_push) wf_wp_q <= inc_ptr(wf_wp_q);
            if (wf_pop)  wf_rp_q <= inc_ptr(wf_rp_q);
            if (wf_push && !wf_pop) wf_cnt_q <= wf_cnt_q + 1'b1;
            else if (wf_pop && !wf_push) wf_cnt_q <= wf_cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: every read port is gated by its occupancy count.
    always_ff @(posedge clock) begin
        if (rf_push) rf_mem[rf_wp_q] <= sd_rdata;
        if (wf_push) wf_mem[wf_wp_q] <= data_to_ram;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            word_q    <= '0;
            pend_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            pend_q    <= pend_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        pend_d    = pend_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        unique case (state_q)
            StIdle: begin
                if (readreq) begin
                    rd_addr_d = rd_lineaddr;
                    state_d   = StRdCmd;
                    if (writereq) begin
                        wr_addr_d = wr_lineaddr;
                        pend_d    = 1'b1;
                    end
                end else if (writereq) begin
                    wr_addr_d = wr_lineaddr;
                    state_d   = StWrFill;
                end
            end
            StRdCmd: begin
                // Hold off the read burst until the cache has drained the previous line.
                if (rf_cnt_q == '0) begin
                    cmd_valid = 1'b1;
                    cmd_addr  = rd_addr_q;
                    if (cmd_ack) begin
                        state_d = StRdData;
                        word_d  = '0;
                    end
                end
            end
            StRdData: begin
                if (sd_rvalid) begin
                    word_d = word_q + 1'b1;
                    if (word_q == LASTW) begin
                        if (pend_q) begin
                            pend_d  = 1'b0;
                            state_d = StWrFill;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StWrFill: begin
                if (wf_cnt_q == FULL) state_d = StWrCmd;
            end
            StWrCmd: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = wr_addr_q;
                if (cmd_ack) begin
                    state_d = StWrData;
                    word_d  = '0;
                end
            end
            StWrData: begin
                if (sd_wstrobe) begin
                    word_d = word_q + 1'b1;
                    if (word_q == LASTW) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy          = (state_q != StIdle) || pend_q;
    assign writeready    = (wf_cnt_q != FULL);
    assign readready     = (rf_cnt_q != '0);
    assign data_from_ram = readready ? rf_mem[rf_rp_q] : '0;
    assign sd_wdata      = (wf_cnt_q != '0) ? wf_mem[wf_rp_q] : '0;

endmodule

// File: tb/tb_sdram_line_xfer.sv
// Scoreboard bench for sdram_line_xfer: a controller model, a cache model and a
// negedge monitor that pops expected commands and data words as the DUT presents them.
module tb_sdram_line_xfer;
    localparam int LW = 16;
    localparam int AW = 19;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          readreq = 1'b0, writereq = 1'b0;
    logic [AW-1:0] rd_lineaddr = '0, wr_lineaddr = '0;
    logic [15:0]   data_to_ram = '0;
    logic          write = 1'b0, read = 1'b0;
    logic          writeready, readready, busy;
    logic [15:0]   data_from_ram, sd_wdata;
    logic          cmd_valid, cmd_write, cmd_ack;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   sd_rdata;
    logic          sd_rvalid, sd_wstrobe;

    sdram_line_xfer #(.LINEWORDS(LW), .ADDRWIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .readreq(readreq), .writereq(writereq),
        .rd_lineaddr(rd_lineaddr), .wr_lineaddr(wr_lineaddr), .data_to_ram(data_to_ram),
        .write(write), .writeready(writeready), .data_from_ram(data_from_ram), .read(read),
        .readready(readready), .busy(busy), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_ack(cmd_ack), .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
        .sd_wdata(sd_wdata), .sd_wstrobe(sd_wstrobe)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model: the expected command stream and the two data streams in order.
    logic [AW:0] exp_cmd[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];

    int ctl_kind = 0, words_left = 0, ack_wait = 2, words_sent = 0;
    bit stray_req = 0, rd_en = 1, force_pop = 0, rdata_seq = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // SDRAM controller model
    initial begin
        cmd_ack = 0; sd_rvalid = 0; sd_wstrobe = 0; sd_rdata = '0;
        forever begin
            @(posedge clock); #1;
            cmd_ack = 0; sd_rvalid = 0; sd_wstrobe = 0;
            if (!reset_n) begin
                ctl_kind = 0; words_left = 0; ack_wait = 2;
            end else if (stray_req) begin
                sd_rvalid = 1; sd_rdata = 16'hDEAD; stray_req = 0;
            end else if (cmd_valid) begin
                if (ack_wait > 0) ack_wait--;
                else begin
                    cmd_ack = 1;
                    ctl_kind = cmd_write ? 2 : 1;
                    words_left = LW;
                    words_sent = 0;
                    ack_wait = $urandom_range(0, 3);
                end
            end else if (words_left > 0 && $urandom_range(0, 3) != 0) begin
                if (ctl_kind == 1) begin
                    sd_rdata = rdata_seq ? 16'h0100 + 16'(words_sent) : 16'($urandom);
                    sd_rvalid = 1;
                    exp_rd.push_back(sd_rdata);
                end else begin
                    sd_wstrobe = 1;
                end
                words_left--;
                words_sent++;
            end
        end
    end

    // Cache read side
    initial begin
        forever begin
            @(posedge clock); #1;
            read = force_pop || (rd_en && readready && $urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    bit          prev_v = 0, prev_ack = 0, prev_w = 0;
    logic [AW-1:0] prev_a = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_v = 0;
        end else begin
            if (read && readready) begin
                if (exp_rd.size() == 0) fail_now("rd_unexpected_word");
                else check("rd_data", 32'(data_from_ram), 32'(exp_rd.pop_front()));
            end
            if (prev_v && !prev_ack)
                check("cmd_hold", 32'({cmd_valid, cmd_write, cmd_addr}),
                      32'({1'b1, prev_w, prev_a}));
            if (cmd_valid && !cmd_write) check("rdcmd_fifo_empty", 32'(readready), 32'd0);
            if (cmd_valid && cmd_write) check("wrcmd_fifo_full", 32'(writeready), 32'd0);
            if (cmd_valid && cmd_ack) begin
                if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
                else check("cmd", 32'({cmd_write, cmd_addr}), 32'(exp_cmd.pop_front()));
            end
            if (sd_wstrobe) begin
                if (exp_wr.size() == 0) fail_now("wr_unexpected_word");
                else check("wr_data", 32'(sd_wdata), 32'(exp_wr.pop_front()));
            end
            prev_v = cmd_valid; prev_ack = cmd_ack; prev_w = cmd_write; prev_a = cmd_addr;
        end
    end

    task automatic request(bit rd, bit wr, logic [AW-1:0] ra, logic [AW-1:0] wa, bit expect_it);
        @(posedge clock); #1;
        readreq = rd; writereq = wr; rd_lineaddr = ra; wr_lineaddr = wa;
        if (expect_it && rd) exp_cmd.push_back({1'b0, ra});
        if (expect_it && wr) exp_cmd.push_back({1'b1, wa});
        @(posedge clock); #1;
        readreq = 0; writereq = 0;
        rd_lineaddr = AW'($urandom); wr_lineaddr = AW'($urandom);
    endtask

    task automatic push_word(logic [15:0] d);
        @(posedge clock); #1;
        write = 1; data_to_ram = d;
        if (writeready) exp_wr.push_back(d);
        @(posedge clock); #1;
        write = 0; data_to_ram = 16'($urandom);
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        @(negedge clock);
        while (n < 3000 && !(busy == 0 && words_left == 0 && exp_cmd.size() == 0 &&
               exp_wr.size() == 0 && (!rd_en || exp_rd.size() == 0))) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) fail_now({name, "_timeout"});
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_cmd_write"}, 32'(cmd_write), 32'd0);
        check({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_readready"}, 32'(readready), 32'd0);
        check({tag, "_data_from_ram"}, 32'(data_from_ram), 32'd0);
        check({tag, "_sd_wdata"}, 32'(sd_wdata), 32'd0);
        check({tag, "_writeready"}, 32'(writeready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock); #3;
        reset_n = 1;

        // Line fill with a known data pattern.
        rdata_seq = 1;
        request(1, 0, 19'h12345, '0, 1);
        wait_idle("fill");
        rdata_seq = 0;
        check("fill_busy", 32'(busy), 32'd0);
        check("fill_readready", 32'(readready), 32'd0);

        // Eviction: request first, then fill the write FIFO; a stray readreq is ignored.
        request(0, 1, '0, 19'h00042, 1);
        request(1, 0, 19'h7FFFF, '0, 0);
        for (int i = 0; i < LW; i++) begin
            check("evict_writeready", 32'(writeready), 32'd1);
            check("evict_no_cmd_yet", 32'(cmd_valid), 32'd0);
            push_word(16'hA000 + 16'(i));
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end
        wait_idle("evict");
        check("evict_busy", 32'(busy), 32'd0);

        // Simultaneous read and write requests: read first, then pending write.
        for (int i = 0; i < LW; i++) push_word(16'($urandom));
        request(1, 1, 19'h00ABC, 19'h3C3C3, 1);
        wait_idle("both");

        // Full and empty boundaries.
        for (int i = 0; i < LW; i++) push_word(16'hC000 + 16'(i));
        check("wfifo_full", 32'(writeready), 32'd0);
        push_word(16'hBEEF);
        check("rfifo_empty_data", 32'(data_from_ram), 32'd0);
        @(posedge clock); #1; force_pop = 1;
        @(posedge clock); #1; force_pop = 0;
        @(negedge clock);
        check("pop_empty_readready", 32'(readready), 32'd0);
        check("pop_empty_data", 32'(data_from_ram), 32'd0);
        stray_req = 1;
        repeat (3) @(negedge clock);
        check("stray_rvalid_readready", 32'(readready), 32'd0);
        check("stray_rvalid_busy", 32'(busy), 32'd0);
        request(0, 1, '0, 19'h55555, 1);
        wait_idle("drain_full");

        // Stalled cache: the next read burst waits for the read FIFO to empty.
        rd_en = 0;
        request(1, 0, 19'h01010, '0, 1);
        wait_idle("stall_fill");
        check("stall_readready", 32'(readready), 32'd1);
        request(1, 0, 19'h02020, '0, 1);
        repeat (10) @(negedge clock);
        check("stall_no_rdcmd", 32'(cmd_valid), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        rd_en = 1;
        wait_idle("stall_release");

        // Reset in the middle of a read burst.
        words_sent = 0; ctl_kind = 0;
        request(1, 0, 19'h0BEAD, '0, 1);
        begin
            int n = 0;
            while (n < 2000 && !(ctl_kind == 1 && words_sent >= 5)) begin
                @(negedge clock);
                n++;
            end
            if (n >= 2000) fail_now("abort_wait_timeout");
        end
        @(negedge clock); #2;
        reset_n = 0;
        exp_rd.delete(); exp_cmd.delete(); exp_wr.delete();
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1;
        request(1, 0, 19'h00777, '0, 1);
        wait_idle("after_abort");

        // Randomised mix of operations.
        for (int it = 0; it < 8; it++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                request(1, 0, AW'($urandom), '0, 1);
            end else if (op == 1) begin
                request(0, 1, '0, AW'($urandom), 1);
                for (int i = 0; i < LW; i++) push_word(16'($urandom));
            end else begin
                for (int i = 0; i < LW; i++) push_word(16'($urandom));
                request(1, 1, AW'($urandom), AW'($urandom), 1);
            end
            wait_idle("random");
        end
        check("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
